// File: rtl/adam_mem_copy.sv
// Single-port memory copy initiator: for each word, one read then one write, ascending
// from src to dst, with abort and a one-cycle done pulse.
module adam_mem_copy #(
   parameter int ADDR_WIDTH = 32,
   parameter int DATA_WIDTH = 32,
   parameter int STRB_WIDTH = DATA_WIDTH / 8,
   parameter int LEN_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  start,
   input  logic                  abort,
   input  logic [ADDR_WIDTH-1:0] src,
   input  logic [ADDR_WIDTH-1:0] dst,
   input  logic [LEN_WIDTH-1:0]  len,
   output logic                  busy,
   output logic                  done,
   output logic                  aborted,
   output logic [LEN_WIDTH-1:0]  count,
   output logic                  mem_req,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output logic                  mem_we,
   output logic [STRB_WIDTH-1:0] mem_be,
   output logic [DATA_WIDTH-1:0] mem_wdata,
   input  logic [DATA_WIDTH-1:0] mem_rdata
);

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] READ  = 2'd1;
   localparam logic [1:0] WRITE = 2'd2;
   localparam logic [1:0] DONE  = 2'd3;

   localparam logic [ADDR_WIDTH-1:0] WORD_BYTES = ADDR_WIDTH'(STRB_WIDTH);
   localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = ~(WORD_BYTES - ADDR_WIDTH'(1));

   logic [1:0]            state;
   logic [ADDR_WIDTH-1:0] src_ptr;
   logic [ADDR_WIDTH-1:0] dst_ptr;
   logic [LEN_WIDTH-1:0]  remaining;
   logic [LEN_WIDTH-1:0]  count_q;
   logic                  aborted_q;

   // Sequencer: a WRITE cycle always retires its word, even when abort ends the copy there.
   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         src_ptr   <= '0;
         dst_ptr   <= '0;
         remaining <= '0;
         count_q   <= '0;
         aborted_q <= 1'b0;
      end else begin
         case (state)
            IDLE: begin
               if (start) begin
                  src_ptr   <= src & ALIGN_MASK;
                  dst_ptr   <= dst & ALIGN_MASK;
                  remaining <= len;
                  count_q   <= '0;
                  aborted_q <= 1'b0;
                  state     <= (len == '0) ? DONE : READ;
               end
            end
            READ: begin
               if (abort) begin
                  aborted_q <= 1'b1;
                  state     <= DONE;
               end else begin
                  state <= WRITE;
               end
            end
            WRITE: begin
               src_ptr   <= src_ptr + WORD_BYTES;
               dst_ptr   <= dst_ptr + WORD_BYTES;
               count_q   <= count_q + LEN_WIDTH'(1);
               remaining <= remaining - LEN_WIDTH'(1);
               if (abort) begin
                  aborted_q <= 1'b1;
                  state     <= DONE;
               end else if (remaining == LEN_WIDTH'(1)) begin
                  state <= DONE;
               end else begin
                  state <= READ;
               end
            end
            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

   // Outputs decode from registered state only; read data passes straight through on writes.
   always_comb begin
      busy      = 1'b0;
      done      = 1'b0;
      mem_req   = 1'b0;
      mem_we    = 1'b0;
      mem_be    = '0;
      mem_addr  = '0;
      mem_wdata = '0;
      case (state)
         READ: begin
            busy     = 1'b1;
            mem_req  = 1'b1;
            mem_addr = src_ptr;
         end
         WRITE: begin
            busy      = 1'b1;
            mem_req   = 1'b1;
            mem_we    = 1'b1;
            mem_be    = '1;
            mem_addr  = dst_ptr;
            mem_wdata = mem_rdata;
         end
         DONE: begin
            done = 1'b1;
         end
         default: begin
            busy = 1'b0;
         end
      endcase
   end

   assign count   = count_q;
   assign aborted = aborted_q;

endmodule
